i2c_config_sequencer: RTL
=========================

# i2c_config_sequencer

Upstream command source for the I2C byte transmitter. Walks a fixed table of register/value pairs and, for each entry, drives a three-byte write transaction (device address + W, register, value) into the transmitter one byte at a time over a start/busy handshake. Retries NACKed words, enforces bus-free time between transactions, and reports completion or failure to the top-level control logic.

## Interface
- `DEV_ADDR`, 7'h1A: 7-bit target address; first byte = {DEV_ADDR, 1'b0}.
- `NUM_WORDS`, 10: table entries sent, indices 0..NUM_WORDS-1 (1..256).
- `RETRY_MAX`, 3: retries per word after NACK before failing.
- `GAP_CYCLES`, 16: idle Clock cycles between transactions (≥1).
- `TIMEOUT`, 255: cycles to wait for ByteBusy to rise after ByteEnable.

- `Clock` in 1: system clock, rising-edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `Start` in 1: level; sampled in IDLE/DONE/FAIL, begins a full table pass.
- `ByteData` out 8: byte to transmit; stable from ByteEnable until ByteBusy falls.
- `ByteEnable` out 1: one-cycle request to transmitter.
- `ByteLast` out 1: qualifies ByteData; 1 = transmitter issues STOP after this byte.
- `ByteFirst` out 1: 1 = transmitter issues START before this byte.
- `ByteBusy` in 1: transmitter busy; rises ≥1 cycle after ByteEnable, falls when byte + ACK slot complete.
- `ByteAckErr` in 1: NACK flag, valid in the cycle ByteBusy is sampled low after being high.
- `Busy` out 1: pass in progress.
- `Done` out 1: held high after successful pass until next Start.
- `Error` out 1: held high after failure until next Start.
- `WordIndex` out 8: current table index.

## Operation
- Reset: state IDLE; ByteData=0, ByteEnable=0, ByteFirst=0, ByteLast=0, Busy=0, Done=0, Error=0, WordIndex=0, retry and gap/timeout counters 0.
- States: IDLE → LOAD → SEND_DEV → WAIT_DEV → SEND_REG → WAIT_REG → SEND_DAT → WAIT_DAT → GAP → (LOAD | DONE); FAIL terminal.
- IDLE/DONE/FAIL + Start=1: clear Done, Error, WordIndex, retry count; go LOAD; Busy=1.
- LOAD: latch 16-bit table word {reg[15:8], value[7:0]} for WordIndex.
- SEND_x: only if ByteBusy=0; drive ByteData, pulse ByteEnable one cycle, go WAIT_x. SEND_DEV sets ByteFirst=1; SEND_DAT sets ByteLast=1; else both 0.
- WAIT_x: phase 1 waits for ByteBusy=1 (timeout counter running); phase 2 waits ByteBusy=0. On fall: ByteAckErr=0 → next SEND or GAP; ByteAckErr=1 → NACK path.
- NACK path: retry count < RETRY_MAX → increment, GAP, then restart same word at SEND_DEV (no LOAD re-read needed). Else FAIL.
- NACK on SEND_DEV/SEND_REG: sequencer proceeds to GAP; transmitter is responsible for STOP on NACK.
- Timeout (ByteBusy not high within TIMEOUT cycles): FAIL immediately, no retry.
- GAP: count GAP_CYCLES; then if retry pending → SEND_DEV; else WordIndex+1, retry count cleared; WordIndex == NUM_WORDS-1 → DONE, else LOAD.
- DONE: Busy=0, Done=1. FAIL: Busy=0, Error=1, WordIndex frozen at failing entry.
- Start while Busy=1: ignored.
- Reset mid-transaction: immediate return to reset values; transmitter recovers independently.

## Timing
- Start sampled high in IDLE → Busy=1 next cycle; first ByteEnable 2 cycles after Start (LOAD, SEND_DEV).
- ByteEnable never asserted while ByteBusy=1 or in consecutive cycles.
- Byte-to-byte: ByteEnable for next byte 1 cycle after ByteBusy sampled low.
- Word-to-word: exactly GAP_CYCLES cycles from final ByteBusy fall to GAP exit, plus LOAD.
- WordIndex 8-bit, no wrap: pass terminates at NUM_WORDS-1.
- Retry counter width ≥ clog2(RETRY_MAX+1); timeout/gap counters 8-bit, saturating not wrapping.

## Structure
- Shared package: state encoding constants, table word layout (REG_HI=15, REG_LO=8), default DEV_ADDR.
- Sub-module `i2c_config_rom`: combinational index→16-bit word lookup, default entry 16'h0000; sequencer contains only control.

## Test plan
- Nominal: NUM_WORDS=2, table {16'h0F00, 16'h0117}, model ACKs all → bytes 8'h34,8'h0F,8'h00,8'h34,8'h01,8'h17; ByteFirst on 1st/4th, ByteLast on 3rd/6th; Done=1, Error=0.
- Single NACK on word 1 data byte → word 1 resent once after GAP_CYCLES gap; Done=1.
- Persistent NACK on word 0 address byte, RETRY_MAX=3 → exactly 4 attempts; Error=1, WordIndex=0, Busy=0.
- Transmitter never raises ByteBusy → Error=1 TIMEOUT+1 cycles after ByteEnable; no second ByteEnable.
- Reset_n low during WAIT_REG → all outputs reset values asynchronously; subsequent Start completes full pass.
- Start held high during pass, and pulsed after DONE → no restart mid-pass; new pass clears Done, WordIndex=0.

Source files
------------

// File: rtl/i2c_config_sequencer_pkg.sv
// Shared definitions for the I2C configuration sequencer: state encoding,
// table word layout and the default target address.
package i2c_config_sequencer_pkg;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_LOAD     = 4'd1,
      ST_SEND_DEV = 4'd2,
      ST_WAIT_DEV = 4'd3,
      ST_SEND_REG = 4'd4,
      ST_WAIT_REG = 4'd5,
      ST_SEND_DAT = 4'd6,
      ST_WAIT_DAT = 4'd7,
      ST_GAP      = 4'd8,
      ST_DONE     = 4'd9,
      ST_FAIL     = 4'd10
   } state_t;

   localparam int WORD_W = 16;
   localparam int REG_HI = 15;
   localparam int REG_LO = 8;
   localparam int VAL_HI = 7;
   localparam int VAL_LO = 0;

   localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h1A;

   // First byte of every transaction: 7-bit address followed by the write bit.
   function automatic logic [7:0] dev_write_byte(input logic [6:0] addr);
      return {addr, 1'b0};
   endfunction

endpackage

// File: rtl/i2c_config_sequencer_rom.sv
// Fixed register/value table walked by the sequencer; entries beyond the
// populated range read as zero.
module i2c_config_rom
   import i2c_config_sequencer_pkg::*;
(
   input  logic [7:0]        index,
   output logic [WORD_W-1:0] word
);

   // Each entry is {register, value}; the sequencer splits it at REG_LO.
   always_comb begin
      word = 16'h0000;
      case (index)
         8'd0:    word = 16'h0F00;
         8'd1:    word = 16'h0117;
         8'd2:    word = 16'h0217;
         8'd3:    word = 16'h0379;
         8'd4:    word = 16'h0479;
         8'd5:    word = 16'h0512;
         8'd6:    word = 16'h0600;
         8'd7:    word = 16'h0700;
         8'd8:    word = 16'h0842;
         8'd9:    word = 16'h0901;
         default: word = 16'h0000;
      endcase
   end

endmodule

// File: rtl/i2c_config_sequencer.sv
// Walks the configuration table and feeds three-byte write transactions to
// the I2C byte transmitter, with NACK retry, bus-free gap and busy timeout.
module i2c_config_sequencer
   import i2c_config_sequencer_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR   = DEFAULT_DEV_ADDR,
   parameter int         NUM_WORDS  = 10,
   parameter int         RETRY_MAX  = 3,
   parameter int         GAP_CYCLES = 16,
   parameter int         TIMEOUT    = 255
)(
   input  logic       Clock,
   input  logic       Reset_n,
   input  logic       Start,
   output logic [7:0] ByteData,
   output logic       ByteEnable,
   output logic       ByteLast,
   output logic       ByteFirst,
   input  logic       ByteBusy,
   input  logic       ByteAckErr,
   output logic       Busy,
   output logic       Done,
   output logic       Error,
   output logic [7:0] WordIndex
);

   localparam int                 RETRY_W     = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
   localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(RETRY_MAX);
   localparam logic [7:0]         GAP_LAST    = 8'(GAP_CYCLES - 1);
   localparam logic [7:0]         TIMEOUT_LIM = 8'(TIMEOUT);
   localparam logic [7:0]         LAST_INDEX  = 8'(NUM_WORDS - 1);

   state_t             state_q, state_n;
   logic [WORD_W-1:0]  word_q, word_n;
   logic [WORD_W-1:0]  rom_word;
   logic [7:0]         data_q, data_n;
   logic               en_q, en_n;
   logic               first_q, first_n;
   logic               last_q, last_n;
   logic [7:0]         idx_q, idx_n;
   logic [RETRY_W-1:0] retry_q, retry_n;
   logic               pending_q, pending_n;
   logic [7:0]         cnt_q, cnt_n;
   logic               seen_busy_q, seen_busy_n;

   i2c_config_rom rom (
      .index (idx_q),
      .word  (rom_word)
   );

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) state_q <= ST_IDLE;
      else          state_q <= state_n;
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         word_q      <= '0;
         data_q      <= '0;
         en_q        <= 1'b0;
         first_q     <= 1'b0;
         last_q      <= 1'b0;
         idx_q       <= '0;
         retry_q     <= '0;
         pending_q   <= 1'b0;
         cnt_q       <= '0;
         seen_busy_q <= 1'b0;
      end else begin
         word_q      <= word_n;
         data_q      <= data_n;
         en_q        <= en_n;
         first_q     <= first_n;
         last_q      <= last_n;
         idx_q       <= idx_n;
         retry_q     <= retry_n;
         pending_q   <= pending_n;
         cnt_q       <= cnt_n;
         seen_busy_q <= seen_busy_n;
      end
   end

   // ByteEnable is registered so it is a clean single-cycle pulse that
   // coincides with ByteData already being stable.
   always_comb begin
      state_n     = state_q;
      word_n      = word_q;
      data_n      = data_q;
      en_n        = 1'b0;
      first_n     = first_q;
      last_n      = last_q;
      idx_n       = idx_q;
      retry_n     = retry_q;
      pending_n   = pending_q;
      cnt_n       = cnt_q;
      seen_busy_n = seen_busy_q;

      case (state_q)
         ST_IDLE, ST_DONE, ST_FAIL: begin
            if (Start) begin
               idx_n     = '0;
               retry_n   = '0;
               pending_n = 1'b0;
               state_n   = ST_LOAD;
            end
         end

         ST_LOAD: begin
            word_n  = rom_word;
            state_n = ST_SEND_DEV;
         end

         ST_SEND_DEV: begin
            if (!ByteBusy) begin
               data_n      = dev_write_byte(DEV_ADDR);
               en_n        = 1'b1;
               first_n     = 1'b1;
               last_n      = 1'b0;
               cnt_n       = '0;
               seen_busy_n = 1'b0;
               state_n     = ST_WAIT_DEV;
            end
         end

         ST_SEND_REG: begin
            if (!ByteBusy) begin
               data_n      = word_q[REG_HI:REG_LO];
               en_n        = 1'b1;
               first_n     = 1'b0;
               last_n      = 1'b0;
               cnt_n       = '0;
               seen_busy_n = 1'b0;
               state_n     = ST_WAIT_REG;
            end
         end

         ST_SEND_DAT: begin
            if (!ByteBusy) begin
               data_n      = word_q[VAL_HI:VAL_LO];
               en_n        = 1'b1;
               first_n     = 1'b0;
               last_n      = 1'b1;
               cnt_n       = '0;
               seen_busy_n = 1'b0;
               state_n     = ST_WAIT_DAT;
            end
         end

         // Phase 1 waits for the transmitter to accept (bounded), phase 2
         // waits for the byte and its ACK slot to finish.
         ST_WAIT_DEV, ST_WAIT_REG, ST_WAIT_DAT: begin
            if (!seen_busy_q) begin
               if (ByteBusy) begin
                  seen_busy_n = 1'b1;
               end else if (cnt_q >= TIMEOUT_LIM) begin
                  state_n = ST_FAIL;
               end else if (cnt_q != 8'hFF) begin
                  cnt_n = cnt_q + 8'd1;
               end
            end else if (!ByteBusy) begin
               seen_busy_n = 1'b0;
               cnt_n       = '0;
               if (ByteAckErr) begin
                  if (retry_q < RETRY_LIMIT) begin
                     retry_n   = retry_q + RETRY_W'(1);
                     pending_n = 1'b1;
                     state_n   = ST_GAP;
                  end else begin
                     state_n = ST_FAIL;
                  end
               end else begin
                  case (state_q)
                     ST_WAIT_DEV: state_n = ST_SEND_REG;
                     ST_WAIT_REG: state_n = ST_SEND_DAT;
                     default:     state_n = ST_GAP;
                  endcase
               end
            end
         end

         // A pending retry resends the already latched word without a LOAD.
         ST_GAP: begin
            if (cnt_q >= GAP_LAST) begin
               cnt_n = '0;
               if (pending_q) begin
                  pending_n = 1'b0;
                  state_n   = ST_SEND_DEV;
               end else begin
                  retry_n = '0;
                  if (idx_q == LAST_INDEX) begin
                     state_n = ST_DONE;
                  end else begin
                     idx_n   = idx_q + 8'd1;
                     state_n = ST_LOAD;
                  end
               end
            end else begin
               cnt_n = cnt_q + 8'd1;
            end
         end

         default: state_n = ST_IDLE;
      endcase
   end

   assign ByteData   = data_q;
   assign ByteEnable = en_q;
   assign ByteFirst  = first_q;
   assign ByteLast   = last_q;
   assign WordIndex  = idx_q;
   assign Busy       = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_FAIL);
   assign Done       = (state_q == ST_DONE);
   assign Error      = (state_q == ST_FAIL);

endmodule
